unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Arbiter and sequencer that shares one single-port unified memory between the pipeline's instruction-fetch port (IF stage) and data port (MEM stage). It serialises accesses through a three-state FSM, registers the memory command, waits for the memory's acknowledge and returns read data with a one-cycle completion pulse. It also drives per-port stall signals back to the pipeline control, and it supports killing an in-flight fetch on a branch or jump flush.

## Interface
Parameters:
- AW, 10: memory word-address width; mem_addr = requester byte address [AW+1:2].
- STARVE, 4: maximum consecutive data grants while a fetch is waiting (legal range 1..15).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; held until i_done
- i_addr  in  32  fetch byte address
- i_kill  in  1  flush; cancels delivery of the current/outstanding fetch
- i_rdata  out  32  last completed instruction word
- i_done  out  1  one-cycle fetch completion pulse
- i_stall  out  1  i_req & ~i_done (combinational)
- d_req  in  1  data request; held until d_done
- d_we  in  1  1 = store, 0 = load
- d_be  in  4  store byte enables
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_rdata  out  32  last completed load word
- d_done  out  1  one-cycle data completion pulse
- d_stall  out  1  d_req & ~d_done (combinational)
- mem_cmd  out  1  one-cycle command strobe to memory
- mem_we  out  1  write enable for the command
- mem_be  out  4  byte enables for the command
- mem_addr  out  AW  word address
- mem_wdata  out  32  write data
- mem_ack  in  1  memory completion, one-cycle pulse
- mem_rdata  in  32  read data, valid with mem_ack

## Operation
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- IDLE, no request: remain in IDLE.
- IDLE, request present: grant one owner.
  - Data wins over fetch unless the starvation counter equals STARVE and i_req is high; in that case fetch wins.
  - Latch owner, mem_addr, mem_we, mem_be and mem_wdata. Set mem_cmd for exactly one cycle. Go to WAIT.
- Fetch grant command: mem_we=0, mem_be=4'hF, mem_wdata=0.
- Data grant command: mem_we=d_we, mem_be = d_we ? d_be : 4'hF, mem_wdata=d_wdata.
- WAIT: hold the command registers. mem_ack in the mem_cmd cycle is ignored. A later mem_ack causes:
  - Load or fetch owner: capture mem_rdata into the owner's rdata register. Stores leave d_rdata unchanged.
  - Go to DONE.
- DONE: assert the owner's done for this one cycle. No arbitration. Next state is IDLE.
- Kill:
  - If i_kill is high in any cycle while the owner is fetch (WAIT or DONE), set a kill flag.
  - A killed fetch still completes on the memory side, but i_rdata is not updated and i_done stays 0.
  - i_kill in IDLE has no effect.
- Starvation counter (4-bit):
  - On a data grant with i_req high: +1, saturating at STARVE.
  - On a data grant with i_req low: cleared.
  - On any fetch grant: cleared.
- mem_ack in IDLE or DONE is ignored. State and outputs are unchanged.

## Timing
- Reset (rst low, asynchronous): state=IDLE. All registered outputs are 0: i_rdata, d_rdata, i_done, d_done, mem_cmd, mem_we, mem_be, mem_addr, mem_wdata. Kill flag and counter are 0. An outstanding access is abandoned.
- Minimum latency with the request seen in IDLE at cycle t:
  - mem_cmd=1 in cycle t+1.
  - Earliest accepted mem_ack in cycle t+2.
  - done=1 and rdata valid in cycle t+3.
  - IDLE again in cycle t+4.
  - Minimum access period is 4 cycles.
- Memory-induced latency extends WAIT without bound. There is no timeout.
- Requester rule: req, addr and data stay stable from assertion through the done cycle. The cycle after done (IDLE) samples the next request.
- Simultaneous i_req and d_req in IDLE: data is granted, subject to the starvation rule. The fetch waits with i_stall=1.
- i_kill coincident with mem_ack: the kill applies, so there is no i_done and no i_rdata update.
- i_stall and d_stall drop combinationally in the done cycle.

## Test plan
- Single fetch: i_addr=0x0000_0010, memory acks 2 cycles after mem_cmd with 0x2002_0005 -> mem_addr=4, mem_we=0, mem_be=F; i_done one cycle; i_rdata=0x2002_0005; i_stall low only in the done cycle.
- Store then load: d_we=1, d_be=4'b0011, d_addr=0x0000_0008, d_wdata=0xDEAD_BEEF -> mem_cmd with mem_addr=2, mem_be=3, mem_we=1, d_done, d_rdata unchanged. Then a load of the same address, acked with 0x0000_BEEF -> d_rdata=0x0000_BEEF.
- Contention: i_req and d_req both held continuously, STARVE=4, memory acks after 1 cycle -> grant order D,D,D,D,I,D,D,D,D,I. Fetch never waits more than 4 data accesses.
- Kill: fetch granted, i_kill pulsed in WAIT, ack with 0xFFFF_FFFF -> i_done never asserts, i_rdata retains its old value, FSM returns to IDLE on schedule.
- Reset mid-access: rst low during WAIT, then a late mem_ack after release -> state IDLE, all outputs 0, stray ack ignored, next request serviced normally.
- Stray ack: mem_ack pulsed in IDLE and in the mem_cmd cycle -> no done pulse, no rdata change, no state change.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between the instruction-fetch and data ports.
// Each access is one command; done pulses one cycle after the accepted acknowledge.
module unified_mem_arbiter #(
    parameter int AW     = 10,
    parameter int STARVE = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [31:0]   i_addr,
    input  logic          i_kill,
    output logic [31:0]   i_rdata,
    output logic          i_done,
    output logic          i_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_be,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    output logic [31:0]   d_rdata,
    output logic          d_done,
    output logic          d_stall,
    output logic          mem_cmd,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_C = 4'(STARVE);

    state_t          state_r;
    state_t          next_state_s;
    logic            grant_s;
    logic            grant_fetch_s;
    logic            ack_ok_s;
    logic            kill_eff_s;
    logic            owner_fetch_r;
    logic            kill_r;
    logic [3:0]      starve_cnt_r;
    logic [AW-1:0]   cmd_addr_s;
    logic            cmd_we_s;
    logic [3:0]      cmd_be_s;
    logic [31:0]     cmd_wdata_s;
    logic            unused_s;

    assign unused_s   = ^{i_addr[31:AW+2], i_addr[1:0], d_addr[31:AW+2], d_addr[1:0]};
    assign i_stall    = i_req & ~i_done;
    assign d_stall    = d_req & ~d_done;
    // A kill in the acknowledge cycle itself must already suppress delivery.
    assign kill_eff_s = kill_r | i_kill;

    // Next-state logic: arbitration in IDLE, acknowledge acceptance in WAIT.
    always_comb begin
        next_state_s  = state_r;
        grant_s       = 1'b0;
        grant_fetch_s = 1'b0;
        ack_ok_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_req || d_req) begin
                    grant_s       = 1'b1;
                    grant_fetch_s = i_req && (!d_req || (starve_cnt_r == STARVE_C));
                    next_state_s  = WAIT;
                end else begin
                    next_state_s  = IDLE;
                end
            end
            WAIT: begin
                // An ack alongside our own command strobe cannot belong to it.
                if (mem_ack && !mem_cmd) begin
                    ack_ok_s     = 1'b1;
                    next_state_s = DONE;
                end else begin
                    next_state_s = WAIT;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Command field selection for the winning requester.
    always_comb begin
        cmd_addr_s  = {AW{1'b0}};
        cmd_we_s    = 1'b0;
        cmd_be_s    = 4'hF;
        cmd_wdata_s = 32'h0000_0000;
        if (grant_fetch_s) begin
            cmd_addr_s  = i_addr[AW+1:2];
            cmd_we_s    = 1'b0;
            cmd_be_s    = 4'hF;
            cmd_wdata_s = 32'h0000_0000;
        end else begin
            cmd_addr_s  = d_addr[AW+1:2];
            cmd_we_s    = d_we;
            cmd_be_s    = d_we ? d_be : 4'hF;
            cmd_wdata_s = d_wdata;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Memory command registers, held stable for the whole access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_cmd       <= 1'b0;
            mem_we        <= 1'b0;
            mem_be        <= 4'h0;
            mem_addr      <= {AW{1'b0}};
            mem_wdata     <= 32'h0000_0000;
            owner_fetch_r <= 1'b0;
        end else begin
            mem_cmd <= grant_s;
            if (grant_s) begin
                mem_we        <= cmd_we_s;
                mem_be        <= cmd_be_s;
                mem_addr      <= cmd_addr_s;
                mem_wdata     <= cmd_wdata_s;
                owner_fetch_r <= grant_fetch_s;
            end
        end
    end

    // Kill flag: armed by a flush while a fetch owns the memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kill_r <= 1'b0;
        end else if (grant_s) begin
            kill_r <= 1'b0;
        end else if ((state_r != IDLE) && owner_fetch_r && i_kill) begin
            kill_r <= 1'b1;
        end
    end

    // Starvation counter: consecutive data grants that bypassed a waiting fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_r <= 4'd0;
        end else if (grant_s) begin
            if (grant_fetch_s || !i_req) begin
                starve_cnt_r <= 4'd0;
            end else if (starve_cnt_r != STARVE_C) begin
                starve_cnt_r <= starve_cnt_r + 4'd1;
            end
        end
    end

    // Completion pulses and read-data capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_done  <= 1'b0;
            d_done  <= 1'b0;
            i_rdata <= 32'h0000_0000;
            d_rdata <= 32'h0000_0000;
        end else begin
            i_done <= ack_ok_s && owner_fetch_r && !kill_eff_s;
            d_done <= ack_ok_s && !owner_fetch_r;
            if (ack_ok_s && owner_fetch_r && !kill_eff_s) begin
                i_rdata <= mem_rdata;
            end
            if (ack_ok_s && !owner_fetch_r && !mem_we) begin
                d_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: vector table with scoreboard, plus contention,
// kill, stray-acknowledge and reset-during-access sequences.
module tb_unified_mem_arbiter;

    localparam int AW     = 10;
    localparam int STARVE = 4;
    localparam logic [31:0] C_DATA = 32'h600D_0001;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, i_kill, d_req, d_we, mem_ack;
    logic [31:0]   i_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]    d_be;
    logic [31:0]   i_rdata, d_rdata, mem_wdata;
    logic          i_done, i_stall, d_done, d_stall, mem_cmd, mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;

    typedef struct {
        logic          fetch;
        logic          we;
        logic [3:0]    be;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        int            delay;
        logic [31:0]   ackdata;
        logic [AW-1:0] exp_maddr;
        logic          exp_we;
        logic [3:0]    exp_be;
        logic [31:0]   exp_wdata;
        logic [31:0]   exp_rdata;
    } vec_t;

    vec_t          vecs[5];
    vec_t          sb_q[$];
    logic          grant_q[$];
    logic          exp_order[10];
    int            checks = 0;
    int            failures = 0;
    int            cmd_cnt = 0, i_done_cnt = 0, d_done_cnt = 0, ack_cnt = 0;
    int            mem_delay = 1;
    logic [31:0]   mem_data = 32'h0;
    logic          resp_en = 1'b1;
    logic [AW-1:0] cmd_addr;
    logic          cmd_we;
    logic [3:0]    cmd_be;
    logic [31:0]   cmd_wdata;

    unified_mem_arbiter #(.AW(AW), .STARVE(STARVE)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_rdata(i_rdata),
        .i_done(i_done), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
        .mem_cmd(mem_cmd), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial forever #5 clk = ~clk;

    // Event counters sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_cmd) cmd_cnt <= cmd_cnt + 1;
        if (i_done)  i_done_cnt <= i_done_cnt + 1;
        if (d_done)  d_done_cnt <= d_done_cnt + 1;
    end

    // Memory model: records each command and acks mem_delay cycles after it.
    initial begin
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (resp_en) begin
                mem_ack = 1'b0;
                if (mem_cmd === 1'b1) begin
                    cmd_addr = mem_addr; cmd_we = mem_we; cmd_be = mem_be; cmd_wdata = mem_wdata;
                    grant_q.push_back(mem_addr == 10'h040);
                    for (int k = 0; k < mem_delay; k++) begin
                        @(posedge clk); #1;
                    end
                    mem_ack = 1'b1;
                    mem_rdata = mem_data;
                    ack_cnt++;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic f, input logic we, input logic [3:0] be,
                                input logic [31:0] a, input logic [31:0] wd, input int dl,
                                input logic [31:0] ad, input logic [AW-1:0] ema,
                                input logic ewe, input logic [3:0] ebe,
                                input logic [31:0] ewd, input logic [31:0] erd);
        vec_t v;
        v.fetch = f; v.we = we; v.be = be; v.addr = a; v.wdata = wd; v.delay = dl;
        v.ackdata = ad; v.exp_maddr = ema; v.exp_we = ewe; v.exp_be = ebe;
        v.exp_wdata = ewd; v.exp_rdata = erd;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        vec_t e;
        int   n, c0;
        logic got, stall_bad;
        mem_delay = v.delay;
        mem_data = v.ackdata;
        sb_q.push_back(v);
        c0 = cmd_cnt;
        @(posedge clk); #1;
        if (v.fetch) begin
            i_req = 1'b1; i_addr = v.addr;
        end else begin
            d_req = 1'b1; d_we = v.we; d_be = v.be; d_addr = v.addr; d_wdata = v.wdata;
        end
        n = 0; got = 1'b0; stall_bad = 1'b0;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            if (v.fetch ? i_done : d_done) got = 1'b1;
            else if ((v.fetch ? i_stall : d_stall) !== 1'b1) stall_bad = 1'b1;
        end
        e = sb_q.pop_front();
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, "_latency"}, 32'(n), 32'(e.delay + 3));
            check({tag, "_rdata"}, e.fetch ? i_rdata : d_rdata, e.exp_rdata);
            check({tag, "_stall_at_done"}, 32'(e.fetch ? i_stall : d_stall), 32'd0);
            check({tag, "_stall_before_done"}, 32'(stall_bad), 32'd0);
            check({tag, "_mem_addr"}, 32'(cmd_addr), 32'(e.exp_maddr));
            check({tag, "_mem_we"}, 32'(cmd_we), 32'(e.exp_we));
            check({tag, "_mem_be"}, 32'(cmd_be), 32'(e.exp_be));
            check({tag, "_mem_wdata"}, cmd_wdata, e.exp_wdata);
        end
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk); #1;
        check({tag, "_done_one_cycle"}, 32'(i_done | d_done), 32'd0);
        check({tag, "_cmd_count"}, 32'(cmd_cnt - c0), 32'd1);
    endtask

    task automatic wait_cmd(output logic ok);
        int n;
        ok = 1'b0; n = 0;
        while (!ok && n < 20) begin
            @(negedge clk);
            n++;
            if (mem_cmd) ok = 1'b1;
        end
    endtask

    initial begin
        logic ok;
        int   n, c0, ic0, dc0, a0;
        rst = 1'b0; i_req = 1'b0; i_addr = 32'h0; i_kill = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;

        vecs[0] = mk(1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0, 2, 32'h2002_0005,
                     10'h004, 1'b0, 4'hF, 32'h0, 32'h2002_0005);
        vecs[1] = mk(1'b0, 1'b1, 4'b0011, 32'h0000_0008, 32'hDEAD_BEEF, 1, 32'h1234_5678,
                     10'h002, 1'b1, 4'h3, 32'hDEAD_BEEF, 32'h0);
        vecs[2] = mk(1'b0, 1'b0, 4'h0, 32'h0000_0008, 32'hCAFE_0000, 1, 32'h0000_BEEF,
                     10'h002, 1'b0, 4'hF, 32'hCAFE_0000, 32'h0000_BEEF);
        vecs[3] = mk(1'b1, 1'b0, 4'h0, 32'hABCD_0FFC, 32'h0, 3, 32'h1357_9BDF,
                     10'h3FF, 1'b0, 4'hF, 32'h0, 32'h1357_9BDF);
        vecs[4] = mk(1'b0, 1'b1, 4'b1000, 32'h0000_0FF0, 32'h0102_0304, 4, 32'hFFFF_FFFF,
                     10'h3FC, 1'b1, 4'h8, 32'h0102_0304, 32'h0000_BEEF);
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_outputs", {i_rdata ^ d_rdata ^ mem_wdata}, 32'h0);
        check("rst_ctrl", 32'({i_done, d_done, mem_cmd, mem_we, mem_be, mem_addr}), 32'h0);
        check("rst_stall", 32'({i_stall, d_stall}), 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Contention: both requesters held, STARVE data grants then one fetch.
        grant_q.delete();
        mem_delay = 1; mem_data = C_DATA;
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h0000_0100;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h0000_0200; d_wdata = 32'h0;
        n = 0;
        while (grant_q.size() < 10 && n < 200) begin @(negedge clk); n++; end
        while (!i_done && n < 300) begin @(negedge clk); n++; end
        i_req = 1'b0; d_req = 1'b0;
        check("contention_grant_count", 32'(grant_q.size()), 32'd10);
        for (int k = 0; k < 10; k++) begin
            if (k < grant_q.size()) check($sformatf("contention_grant%0d", k),
                                          32'(grant_q[k]), 32'(exp_order[k]));
        end
        repeat (3) @(negedge clk);

        // Kill pulsed in WAIT
        #1; ic0 = i_done_cnt; c0 = cmd_cnt; a0 = ack_cnt;
        mem_delay = 3; mem_data = 32'hFFFF_FFFF;
        @(posedge clk); #1; i_req = 1'b1; i_addr = 32'h0000_0100;
        wait_cmd(ok);
        check("kill1_cmd_seen", 32'(ok), 32'd1);
        @(posedge clk); #1; i_kill = 1'b1; i_req = 1'b0;
        @(posedge clk); #1; i_kill = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        check("kill1_no_done", 32'(i_done_cnt - ic0), 32'd0);
        check("kill1_rdata_kept", i_rdata, C_DATA);
        check("kill1_mem_acked", 32'(ack_cnt - a0), 32'd1);
        check("kill1_one_cmd", 32'(cmd_cnt - c0), 32'd1);

        // Kill coincident with the acknowledge
        ic0 = i_done_cnt;
        mem_delay = 2; mem_data = 32'hFFFF_FFFF;
        @(posedge clk); #1; i_req = 1'b1; i_addr = 32'h0000_0104;
        wait_cmd(ok);
        check("kill2_cmd_seen", 32'(ok), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1; i_kill = 1'b1;
        @(posedge clk); #1; i_kill = 1'b0; i_req = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("kill2_no_done", 32'(i_done_cnt - ic0), 32'd0);
        check("kill2_rdata_kept", i_rdata, C_DATA);
        run_vec(mk(1'b1, 1'b0, 4'h0, 32'h0000_0020, 32'h0, 1, 32'h0BAD_F00D,
                   10'h008, 1'b0, 4'hF, 32'h0, 32'h0BAD_F00D), "post_kill");

        // Stray acks: in IDLE, in the command cycle and in DONE
        resp_en = 1'b0;
        dc0 = d_done_cnt; c0 = cmd_cnt;
        @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = 32'hAAAA_5555;
        @(posedge clk); #1; mem_ack = 1'b0;
        @(negedge clk); #1;
        check("stray_idle_no_done", 32'(d_done_cnt - dc0), 32'd0);
        check("stray_idle_rdata", d_rdata, C_DATA);
        check("stray_idle_no_cmd", 32'(cmd_cnt - c0), 32'd0);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h0000_0044; d_wdata = 32'h0;
        ok = 1'b0; n = 0;
        while (!ok && n < 10) begin
            @(posedge clk); #1; n++;
            if (mem_cmd) begin mem_ack = 1'b1; mem_rdata = 32'h1111_1111; ok = 1'b1; end
        end
        check("stray_cmd_seen", 32'(ok), 32'd1);
        @(posedge clk); #1; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("stray_cmdcycle_no_done", 32'(d_done_cnt - dc0), 32'd0);
        @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
        @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = 32'h3333_3333;
        @(negedge clk);
        check("stray_real_done", 32'(d_done), 32'd1);
        check("stray_real_rdata", d_rdata, 32'h2222_2222);
        @(posedge clk); #1; mem_ack = 1'b0; d_req = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("stray_done_ack_rdata", d_rdata, 32'h2222_2222);
        check("stray_done_count", 32'(d_done_cnt - dc0), 32'd1);
        check("stray_cmd_count", 32'(cmd_cnt - c0), 32'd1);

        // Reset during WAIT, then a late ack after release
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h0000_0030;
        wait_cmd(ok);
        check("rstmid_cmd_seen", 32'(ok), 32'd1);
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0; d_req = 1'b0;
        #1;
        check("rstmid_rdata", i_rdata | d_rdata, 32'h0);
        check("rstmid_wdata", mem_wdata, 32'h0);
        check("rstmid_ctrl", 32'({i_done, d_done, mem_cmd, mem_we, mem_be, mem_addr}), 32'h0);
        @(negedge clk); rst = 1'b1;
        #1; dc0 = d_done_cnt; c0 = cmd_cnt;
        @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = 32'h0000_0055;
        @(posedge clk); #1; mem_ack = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("rstmid_late_ack_no_done", 32'(d_done_cnt - dc0), 32'd0);
        check("rstmid_late_ack_rdata", d_rdata, 32'h0);
        check("rstmid_no_cmd", 32'(cmd_cnt - c0), 32'd0);
        resp_en = 1'b1;
        run_vec(mk(1'b0, 1'b0, 4'h0, 32'h0000_0030, 32'h0, 1, 32'h7777_0001,
                   10'h00C, 1'b0, 4'hF, 32'h0, 32'h7777_0001), "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
